mem_responder: RTL and testbench
================================

# mem_responder

Byte-addressable data/instruction memory that answers the control unit's memory handshake. The control unit raises MOV with R/W, address (from MAR) and write data (from MDR); this block serves the access after a programmable wait and returns MOC, holding it until MOV drops (four-phase handshake). It sits between the datapath's MAR/MDR and the control unit's MOC input, and supports the byte, halfword and word transfers required by the load/store instructions.

## Interface

Parameters:
- ADDR_W, 8, number of address bits used; memory depth is 2^ADDR_W bytes.
- WAIT_CYCLES, 2, cycles spent in WAIT before the access completes; legal range 0–15.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- MOV  in  1  memory operation valid (request) from the control unit.
- RW  in  1  1 = read, 0 = write; sampled with MOV.
- DT  in  2  data type: 00 = byte, 01 = halfword, 10 = word, 11 = word.
- ADDR  in  32  byte address; only ADDR[ADDR_W-1:0] is used (upper bits ignored, modulo wrap).
- DATA_IN  in  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
- DATA_OUT  out  32  read data, zero-extended, right-justified.
- MOC  out  1  memory operation complete.
- ALIGN_ERR  out  1  misaligned access flag; valid only while MOC = 1.

## Operation

- Storage: 2^ADDR_W × 8-bit array, big-endian. Word at address a: [31:24] = mem[a], [23:16] = mem[a+1], [15:8] = mem[a+2], [7:0] = mem[a+3]. Halfword at address a: [15:8] = mem[a], [7:0] = mem[a+1].
- Alignment: a halfword requires ADDR[0] = 0; a word requires ADDR[1:0] = 00. A misaligned access performs no write, leaves DATA_OUT unchanged, and completes normally with ALIGN_ERR = 1.
- States:
  - IDLE: MOC = 0. If MOV = 1 at the rising edge, latch RW, DT, ADDR, DATA_IN and the alignment result, load the wait counter with WAIT_CYCLES, and go to WAIT.
  - WAIT: while the counter is nonzero, decrement it. When the counter is 0, perform the access at the rising edge and go to ACK.
  - ACK: MOC = 1. While MOV = 1, stay in ACK. When MOV = 0 at the rising edge, go to IDLE; MOC falls at that edge.
- Access is performed exactly once per handshake, using the latched values. Changes to ADDR, DATA_IN, RW or DT after the request is latched have no effect.
- Read: DATA_OUT is loaded with the zero-extended value. DATA_OUT holds until the next successful read.
- Write: only the addressed bytes are modified.
- Abort: if MOV = 0 at any rising edge while in WAIT, return to IDLE. No access is performed and MOC is never raised.
- Address wrap: a halfword at address 2^ADDR_W−1 is misaligned, so no wrap can occur inside an aligned access.
- Reset (at any time, including mid-access): state = IDLE, MOC = 0, ALIGN_ERR = 0, DATA_OUT = 0, wait counter = 0. Memory contents are not cleared. A pending write is discarded.

## Timing

- MOV sampled high at edge t0. The access occurs and MOC rises at edge t0+WAIT_CYCLES+1.
  - WAIT_CYCLES = 0: MOC rises at t0+1.
  - WAIT_CYCLES = 2: MOC rises at t0+3.
- DATA_OUT and ALIGN_ERR are valid at the same edge MOC rises, and remain stable while MOC = 1.
- MOV sampled low at edge t1 while in ACK: MOC = 0 after t1.
- A new request is accepted no earlier than edge t1+1. MOV still high at t1 is impossible by definition; MOV re-raised at t1+1 starts a new access.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles minimum.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

- Reset: assert RST mid-WAIT of a write to 0x10 -> MOC = 0, DATA_OUT = 0 immediately; a later byte read of 0x10 returns its pre-write value.
- Word write then byte/halfword reads (WAIT_CYCLES = 2):
  - Write word 0xDEADBEEF to 0x20.
  - Byte read of 0x21 -> DATA_OUT = 0x000000AD.
  - Halfword read of 0x22 -> 0x0000BEEF.
  - MOC rises 3 edges after MOV is sampled.
- Byte write merge: write byte 0x5A to 0x23 over 0xDEADBEEF -> word read of 0x20 = 0xDEADBE5A.
- Misalignment:
  - Word write to 0x31 -> MOC = 1 with ALIGN_ERR = 1; word read of 0x30 is unchanged.
  - Halfword read of 0x41 -> ALIGN_ERR = 1 and DATA_OUT keeps its previous value.
- Handshake:
  - Hold MOV high for 5 cycles after MOC -> MOC stays 1 and only one write occurs.
  - Drop MOV during WAIT -> MOC never rises and memory is unchanged.
  - Re-raise MOV the cycle after MOC falls -> the new access completes normally.
- Address wrap: with ADDR_W = 8, word write 0x11223344 to 0x00000104 -> word read of 0x04 returns 0x11223344.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-addressable big-endian memory answering the control unit's MOV/MOC
// four-phase handshake. Byte, halfword and word transfers with alignment checking.
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  DT,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        MOC,
    output logic        ALIGN_ERR
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rw;
    logic [1:0]        r_dt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_misalign;
    logic [31:0]       r_data_out;
    logic              r_moc;
    logic              r_align_err;
    logic [7:0]        r_mem [DEPTH];

    logic [1:0]        w_state_nxt;
    logic              w_latch;
    logic              w_access;
    logic              w_wr_en;
    logic              w_misalign_in;
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;
    logic [31:0]       w_rdata;
    logic              w_unused_addr;

    assign DATA_OUT  = r_data_out;
    assign MOC       = r_moc;
    assign ALIGN_ERR = r_align_err;

    assign w_unused_addr = ^ADDR[31:ADDR_W];
    assign w_misalign_in = ((DT == 2'b01) && ADDR[0]) || (DT[1] && (ADDR[1:0] != 2'b00));
    assign w_a1 = r_addr + ADDR_W'(1);
    assign w_a2 = r_addr + ADDR_W'(2);
    assign w_a3 = r_addr + ADDR_W'(3);
    assign w_wr_en = w_access && !r_rw && !r_misalign;

    // Handshake sequencing: abort in WAIT wins over completing the access
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MOV) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!MOV) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!MOV) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (r_dt)
            2'b00:   w_rdata = {24'd0, r_mem[r_addr]};
            2'b01:   w_rdata = {16'd0, r_mem[r_addr], r_mem[w_a1]};
            default: w_rdata = {r_mem[r_addr], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rw        <= 1'b0;
            r_dt        <= 2'b00;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_misalign  <= 1'b0;
            r_data_out  <= '0;
            r_moc       <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_moc   <= (w_state_nxt == S_ACK);
            if (w_latch) begin
                r_rw       <= RW;
                r_dt       <= DT;
                r_addr     <= ADDR[ADDR_W-1:0];
                r_wdata    <= DATA_IN;
                r_misalign <= w_misalign_in;
                r_cnt      <= CNT_W'(WAIT_CYCLES);
            end else if ((r_state == S_WAIT) && MOV && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_access) begin
                r_align_err <= r_misalign;
            end else if (w_state_nxt != S_ACK) begin
                r_align_err <= 1'b0;
            end
            if (w_access && r_rw && !r_misalign) begin
                r_data_out <= w_rdata;
            end
        end
    end

    // Storage is never reset; only the addressed bytes change
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            case (r_dt)
                2'b00: r_mem[r_addr] <= r_wdata[7:0];
                2'b01: begin
                    r_mem[r_addr] <= r_wdata[15:8];
                    r_mem[w_a1]   <= r_wdata[7:0];
                end
                default: begin
                    r_mem[r_addr] <= r_wdata[31:24];
                    r_mem[w_a1]   <= r_wdata[23:16];
                    r_mem[w_a2]   <= r_wdata[15:8];
                    r_mem[w_a3]   <= r_wdata[7:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed handshake cases plus randomized
// traffic checked every cycle against a transaction-level memory model.
module tb_mem_responder;

    localparam int unsigned AW    = 8;
    localparam int unsigned WC    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        mov;
    logic        rw;
    logic [1:0]  dt;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        moc;
    logic        aerr;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_m [DEPTH];
    logic [31:0] exp_dout;
    logic        exp_moc;
    logic        exp_aerr;
    bit          cmp_en = 1'b0;
    logic        last_aerr;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .CLK(clk), .RST(rst), .MOV(mov), .RW(rw), .DT(dt), .ADDR(addr),
        .DATA_IN(din), .DATA_OUT(dout), .MOC(moc), .ALIGN_ERR(aerr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic mis_m(input logic [1:0] t, input logic [31:0] a);
        return ((t == 2'b01) && a[0]) || (t[1] && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] read_m(input logic [1:0] t, input logic [31:0] a);
        logic [7:0] i;
        i = a[7:0];
        if (t == 2'b00) return {24'd0, mem_m[i]};
        if (t == 2'b01) return {16'd0, mem_m[i], mem_m[i + 8'd1]};
        return {mem_m[i], mem_m[i + 8'd1], mem_m[i + 8'd2], mem_m[i + 8'd3]};
    endfunction

    task automatic write_m(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] i;
        i = a[7:0];
        if (t == 2'b00) begin
            mem_m[i] = d[7:0];
        end else if (t == 2'b01) begin
            mem_m[i] = d[15:8];
            mem_m[i + 8'd1] = d[7:0];
        end else begin
            mem_m[i] = d[31:24];
            mem_m[i + 8'd1] = d[23:16];
            mem_m[i + 8'd2] = d[15:8];
            mem_m[i + 8'd3] = d[7:0];
        end
    endtask

    task automatic scramble();
        addr = $urandom;
        din  = $urandom;
        rw   = 1'($urandom);
        dt   = 2'($urandom);
    endtask

    // One handshake; abort_at in 1..WC+1 drops MOV (or pulses reset) before that edge
    task automatic access(input logic r, input logic [1:0] t, input logic [31:0] a,
                          input logic [31:0] d, input int hold, input int abort_at,
                          input bit use_rst);
        @(negedge clk);
        mov = 1'b1; rw = r; dt = t; addr = a; din = d;
        exp_moc = 1'b0;
        for (int k = 1; k <= int'(WC) + 1; k++) begin
            @(negedge clk);
            scramble();
            if (k == abort_at) begin
                if (use_rst) begin
                    rst = 1'b1;
                    #1;
                    check("rst_moc", {31'd0, moc}, 32'd0);
                    check("rst_data_out", dout, 32'd0);
                    exp_dout = '0;
                    exp_moc  = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                end
                mov = 1'b0;
                exp_moc = 1'b0;
                return;
            end
            if (k == int'(WC) + 1) begin
                exp_moc  = 1'b1;
                exp_aerr = mis_m(t, a);
                if (!mis_m(t, a)) begin
                    if (r) exp_dout = read_m(t, a);
                    else   write_m(t, a, d);
                end
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            scramble();
        end
        @(negedge clk);
        last_aerr = aerr;
        check("moc_before_drop", {31'd0, moc}, 32'd1);
        mov = 1'b0;
        exp_moc = 1'b0;
    endtask

    // Per-cycle comparison against the model expectations
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("moc", {31'd0, moc}, {31'd0, exp_moc});
            check("data_out", dout, exp_dout);
            if (exp_moc) check("align_err", {31'd0, aerr}, {31'd0, exp_aerr});
        end
    end

    initial begin
        rst = 1'b1; mov = 1'b0; rw = 1'b0; dt = 2'b00; addr = '0; din = '0;
        exp_dout = '0; exp_moc = 1'b0; exp_aerr = 1'b0; last_aerr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_moc", {31'd0, moc}, 32'd0);
        check("reset_data_out", dout, 32'd0);
        check("reset_align_err", {31'd0, aerr}, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        for (int i = 0; i < int'(DEPTH); i += 4)
            access(1'b0, 2'b10, 32'(i) | ($urandom & 32'hFFFF_FF00), $urandom, 0, 0, 1'b0);

        // reset mid-WAIT discards the pending write
        access(1'b0, 2'b00, 32'h10, 32'h3C, 0, 0, 1'b0);
        access(1'b0, 2'b00, 32'h10, 32'hA5, 0, 2, 1'b1);
        access(1'b1, 2'b00, 32'h10, 32'h0, 0, 0, 1'b0);
        check("rst_discard", dout, 32'h0000_003C);

        access(1'b0, 2'b10, 32'h20, 32'hDEAD_BEEF, 0, 0, 1'b0);
        access(1'b1, 2'b00, 32'h21, 32'h0, 0, 0, 1'b0);
        check("byte_read_21", dout, 32'h0000_00AD);
        access(1'b1, 2'b01, 32'h22, 32'h0, 0, 0, 1'b0);
        check("half_read_22", dout, 32'h0000_BEEF);
        access(1'b0, 2'b00, 32'h23, 32'h5A, 0, 0, 1'b0);
        access(1'b1, 2'b10, 32'h20, 32'h0, 0, 0, 1'b0);
        check("byte_merge", dout, 32'hDEAD_BE5A);

        access(1'b0, 2'b10, 32'h30, 32'h0102_0304, 0, 0, 1'b0);
        access(1'b0, 2'b10, 32'h31, 32'hCAFE_F00D, 0, 0, 1'b0);
        check("mis_write_aerr", {31'd0, last_aerr}, 32'd1);
        access(1'b1, 2'b10, 32'h30, 32'h0, 0, 0, 1'b0);
        check("mis_write_nochange", dout, 32'h0102_0304);
        access(1'b1, 2'b01, 32'h41, 32'h0, 0, 0, 1'b0);
        check("mis_read_aerr", {31'd0, last_aerr}, 32'd1);
        check("mis_read_hold", dout, 32'h0102_0304);

        access(1'b0, 2'b10, 32'h50, 32'h55AA_1234, 5, 0, 1'b0);
        access(1'b1, 2'b10, 32'h50, 32'h0, 0, 0, 1'b0);
        check("hold_single_write", dout, 32'h55AA_1234);
        access(1'b0, 2'b10, 32'h50, 32'hFFFF_FFFF, 0, 2, 1'b0);
        access(1'b0, 2'b10, 32'h50, 32'hFFFF_FFFF, 0, int'(WC) + 1, 1'b0);
        access(1'b1, 2'b10, 32'h50, 32'h0, 0, 0, 1'b0);
        check("abort_no_write", dout, 32'h55AA_1234);

        access(1'b0, 2'b10, 32'h0000_0104, 32'h1122_3344, 0, 0, 1'b0);
        access(1'b1, 2'b10, 32'h0000_0004, 32'h0, 0, 0, 1'b0);
        check("addr_wrap", dout, 32'h1122_3344);

        repeat (300) begin
            logic [31:0] ra;
            int ab;
            ra = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 127));
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, int'(WC) + 1) : 0;
            access(1'($urandom), 2'($urandom), ra, $urandom, $urandom_range(0, 3), ab, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
